// File: rtl/ball_engine.sv
// rtl/ball_engine.sv - frame-rate ball physics with paddle hits, scoring, serve and game-over sequencing
module ball_engine #(
   parameter int X_MIN       = 0,
   parameter int X_MAX       = 639,
   parameter int Y_MIN       = 0,
   parameter int Y_MAX       = 479,
   parameter int BALL_SIZE   = 4,
   parameter int PADDLE_HW   = 4,
   parameter int MAX_SPEED   = 6,
   parameter int SERVE_DELAY = 60,
   parameter int WIN_SCORE   = 7,
   parameter int SCORE_W     = 4
) (
   input  logic               frame_clk,
   input  logic               Reset,
   input  logic               Start,
   input  logic               Pause,
   input  logic [9:0]         PaddleX,
   input  logic [9:0]         PaddleY,
   input  logic [9:0]         PaddleS,
   input  logic [9:0]         Paddle2X,
   input  logic [9:0]         Paddle2Y,
   input  logic [9:0]         Paddle2S,
   output logic [9:0]         BallX,
   output logic [9:0]         BallY,
   output logic [9:0]         BallS,
   output logic [SCORE_W-1:0] Score1,
   output logic [SCORE_W-1:0] Score2,
   output logic               Hit,
   output logic               Goal,
   output logic               Serving,
   output logic               GameOver
);

   localparam int CNT_W = (SERVE_DELAY < 1) ? 1 : $clog2(SERVE_DELAY + 1);
   localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(SERVE_DELAY);
   localparam logic [SCORE_W-1:0] WIN_V    = SCORE_W'(WIN_SCORE);
   localparam logic [9:0] X_CTR = 10'((X_MIN + X_MAX) / 2);
   localparam logic [9:0] Y_CTR = 10'((Y_MIN + Y_MAX) / 2);
   localparam logic signed [11:0] X_MIN_S = 12'(X_MIN);
   localparam logic signed [11:0] X_MAX_S = 12'(X_MAX);
   localparam logic signed [11:0] Y_MIN_S = 12'(Y_MIN);
   localparam logic signed [11:0] Y_MAX_S = 12'(Y_MAX);
   localparam logic signed [11:0] BS_S    = 12'(BALL_SIZE);
   localparam logic signed [11:0] HIT_X_S = 12'(PADDLE_HW + BALL_SIZE);
   localparam logic signed [11:0] MAX_S   = 12'(MAX_SPEED);
   localparam logic signed [11:0] X_LO    = 12'(X_MIN + BALL_SIZE);
   localparam logic signed [11:0] X_HI    = 12'(X_MAX - BALL_SIZE);
   localparam logic signed [11:0] Y_LO    = 12'(Y_MIN + BALL_SIZE);
   localparam logic signed [11:0] Y_HI    = 12'(Y_MAX - BALL_SIZE);

   typedef enum logic [1:0] {ST_SERVE, ST_PLAY, ST_OVER} state_t;

   state_t             state_q, state_d;
   logic [9:0]         ball_x_q, ball_x_d, ball_y_q, ball_y_d;
   logic signed [3:0]  vx_q, vx_d, vy_q, vy_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
   logic               hit_q, hit_d, goal_q, goal_d;
   logic               serving_q, serving_d, over_q, over_d;
   logic               dir_neg_q, dir_neg_d, tog_q, tog_d;

   logic signed [11:0] bx_s, by_s, vx_s, vy_s, vy_b, mag, spd, vx_h, nx, ny;
   logic               hit_l, hit_r, goal_l, goal_r;
   logic [SCORE_W-1:0] s1_inc, s2_inc;

   function automatic logic signed [11:0] abs12(input logic signed [11:0] a);
      return (a < 12'sd0) ? -a : a;
   endfunction

   function automatic logic [9:0] clamp10(input logic signed [11:0] p,
                                          input logic signed [11:0] lo,
                                          input logic signed [11:0] hi);
      logic signed [11:0] r;
      r = p;
      if (p < lo) r = lo;
      else if (p > hi) r = hi;
      return 10'(r);
   endfunction

   // Widen everything to 12-bit signed so edge tests near zero never wrap
   assign bx_s = $signed({2'b00, ball_x_q});
   assign by_s = $signed({2'b00, ball_y_q});
   assign vx_s = $signed({{8{vx_q[3]}}, vx_q});
   assign vy_s = $signed({{8{vy_q[3]}}, vy_q});

   // Wall bounce on Y only when still moving into the wall
   assign vy_b = ((by_s - BS_S <= Y_MIN_S) && vy_q[3])          ? -vy_s :
                 ((by_s + BS_S >= Y_MAX_S) && (vy_s > 12'sd0))  ? -vy_s : vy_s;

   // Paddle boxes only count while the ball travels toward that paddle
   assign hit_l = (abs12(bx_s - $signed({2'b00, PaddleX})) <= HIT_X_S) &&
                  (abs12(by_s - $signed({2'b00, PaddleY})) <= $signed({2'b00, PaddleS}) + BS_S) &&
                  vx_q[3];
   assign hit_r = (abs12(bx_s - $signed({2'b00, Paddle2X})) <= HIT_X_S) &&
                  (abs12(by_s - $signed({2'b00, Paddle2Y})) <= $signed({2'b00, Paddle2S}) + BS_S) &&
                  (vx_s > 12'sd0);

   assign mag  = abs12(vx_s) + 12'sd1;
   assign spd  = (mag > MAX_S) ? MAX_S : mag;
   assign vx_h = hit_l ? spd : (hit_r ? -spd : vx_s);
   assign nx   = bx_s + vx_h;
   assign ny   = by_s + vy_b;

   // A hit always wins over a goal in the same frame
   assign goal_l = !(hit_l || hit_r) && (bx_s - BS_S <= X_MIN_S);
   assign goal_r = !(hit_l || hit_r) && !goal_l && (bx_s + BS_S >= X_MAX_S);
   assign s1_inc = score1_q + 1'b1;
   assign s2_inc = score2_q + 1'b1;

   // Next-frame state: serve countdown, play physics/scoring, game-over restart, pause hold
   always_comb begin
      state_d   = state_q;
      ball_x_d  = ball_x_q;
      ball_y_d  = ball_y_q;
      vx_d      = vx_q;
      vy_d      = vy_q;
      cnt_d     = cnt_q;
      score1_d  = score1_q;
      score2_d  = score2_q;
      dir_neg_d = dir_neg_q;
      tog_d     = tog_q;
      hit_d     = 1'b0;
      goal_d    = 1'b0;
      if (!Pause) begin
         case (state_q)
            ST_SERVE: begin
               ball_x_d = X_CTR;
               ball_y_d = Y_CTR;
               if (cnt_q == '0) begin
                  state_d = ST_PLAY;
                  vx_d    = dir_neg_q ? -4'sd1 : 4'sd1;
                  vy_d    = tog_q ? 4'sd1 : -4'sd1;
                  tog_d   = ~tog_q;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            ST_PLAY: begin
               vx_d  = 4'(vx_h);
               vy_d  = 4'(vy_b);
               hit_d = hit_l | hit_r;
               if (goal_l || goal_r) begin
                  goal_d   = 1'b1;
                  ball_x_d = X_CTR;
                  ball_y_d = Y_CTR;
                  cnt_d    = CNT_INIT;
                  if (goal_l) begin
                     score2_d  = s2_inc;
                     dir_neg_d = 1'b1;
                     state_d   = (s2_inc == WIN_V) ? ST_OVER : ST_SERVE;
                  end else begin
                     score1_d  = s1_inc;
                     dir_neg_d = 1'b0;
                     state_d   = (s1_inc == WIN_V) ? ST_OVER : ST_SERVE;
                  end
               end else begin
                  ball_x_d = clamp10(nx, X_LO, X_HI);
                  ball_y_d = clamp10(ny, Y_LO, Y_HI);
               end
            end
            ST_OVER: begin
               ball_x_d = X_CTR;
               ball_y_d = Y_CTR;
               if (Start) begin
                  score1_d = '0;
                  score2_d = '0;
                  cnt_d    = CNT_INIT;
                  state_d  = ST_SERVE;
               end
            end
            default: state_d = ST_SERVE;
         endcase
      end
      serving_d = (state_d == ST_SERVE);
      over_d    = (state_d == ST_OVER);
   end

   // Frame register with synchronous reset overriding pause
   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state_q   <= ST_SERVE;
         ball_x_q  <= X_CTR;
         ball_y_q  <= Y_CTR;
         vx_q      <= 4'sd1;
         vy_q      <= -4'sd1;
         cnt_q     <= CNT_INIT;
         score1_q  <= '0;
         score2_q  <= '0;
         dir_neg_q <= 1'b0;
         tog_q     <= 1'b0;
         hit_q     <= 1'b0;
         goal_q    <= 1'b0;
         serving_q <= 1'b1;
         over_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ball_x_q  <= ball_x_d;
         ball_y_q  <= ball_y_d;
         vx_q      <= vx_d;
         vy_q      <= vy_d;
         cnt_q     <= cnt_d;
         score1_q  <= score1_d;
         score2_q  <= score2_d;
         dir_neg_q <= dir_neg_d;
         tog_q     <= tog_d;
         hit_q     <= hit_d;
         goal_q    <= goal_d;
         serving_q <= serving_d;
         over_q    <= over_d;
      end
   end

   assign BallX    = ball_x_q;
   assign BallY    = ball_y_q;
   assign BallS    = 10'(BALL_SIZE);
   assign Score1   = score1_q;
   assign Score2   = score2_q;
   assign Hit      = hit_q;
   assign Goal     = goal_q;
   assign Serving  = serving_q;
   assign GameOver = over_q;

endmodule

// File: tb/tb_ball_engine.sv
// tb/tb_ball_engine.sv - randomized scoreboard bench for ball_engine against a behavioural game model
module tb_ball_engine;

   localparam int XMIN = 0, XMAX = 99, YMIN = 0, YMAX = 59;
   localparam int BS = 4, HW = 4, MAXS = 6, SD = 3, WIN = 3, SW = 4;
   localparam int CX = (XMIN + XMAX) / 2, CY = (YMIN + YMAX) / 2;
   localparam int N_FRAMES = 4000;

   logic          frame_clk = 1'b0;
   logic          Reset = 1'b1, Start = 1'b0, Pause = 1'b0;
   logic [9:0]    PaddleX = 10'd0, PaddleY = 10'd0, PaddleS = 10'd0;
   logic [9:0]    Paddle2X = 10'd99, Paddle2Y = 10'd0, Paddle2S = 10'd0;
   logic [9:0]    BallX, BallY, BallS;
   logic [SW-1:0] Score1, Score2;
   logic          Hit, Goal, Serving, GameOver;

   ball_engine #(
      .X_MIN(XMIN), .X_MAX(XMAX), .Y_MIN(YMIN), .Y_MAX(YMAX),
      .BALL_SIZE(BS), .PADDLE_HW(HW), .MAX_SPEED(MAXS),
      .SERVE_DELAY(SD), .WIN_SCORE(WIN), .SCORE_W(SW)
   ) dut (
      .frame_clk(frame_clk), .Reset(Reset), .Start(Start), .Pause(Pause),
      .PaddleX(PaddleX), .PaddleY(PaddleY), .PaddleS(PaddleS),
      .Paddle2X(Paddle2X), .Paddle2Y(Paddle2Y), .Paddle2S(Paddle2S),
      .BallX(BallX), .BallY(BallY), .BallS(BallS),
      .Score1(Score1), .Score2(Score2), .Hit(Hit), .Goal(Goal),
      .Serving(Serving), .GameOver(GameOver)
   );

   always #5 frame_clk = ~frame_clk;

   typedef struct {
      int bx, by, s1, s2, hit, goal, srv, over;
   } exp_t;

   exp_t exp_q[$];
   exp_t last;
   int   n_checks = 0;
   int   n_fail   = 0;

   // Game model: mode 0 = serve, 1 = play, 2 = game over
   int m_mode, m_bx, m_by, m_vx, m_vy, m_cnt, m_s1, m_s2, m_hit, m_goal, m_dir, m_tog;
   int n_hits = 0, n_goals = 0, n_overs = 0;

   function automatic int iabs(input int a);
      return (a < 0) ? -a : a;
   endfunction

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_bx = CX; m_by = CY; m_vx = 1; m_vy = -1; m_cnt = SD;
      m_s1 = 0; m_s2 = 0; m_hit = 0; m_goal = 0; m_dir = 1; m_tog = 0;
   endtask

   task automatic score_goal(input int left_wall);
      int sc;
      m_goal = 1;
      n_goals++;
      if (left_wall) begin m_s2++; m_dir = -1; sc = m_s2; end
      else           begin m_s1++; m_dir = 1;  sc = m_s1; end
      m_bx = CX; m_by = CY; m_cnt = SD;
      m_mode = (sc == WIN) ? 2 : 0;
      if (sc == WIN) n_overs++;
   endtask

   task automatic model_step(input int pause, input int start,
                             input int lx, input int ly, input int ls,
                             input int rx, input int ry, input int rs);
      int nvx, nvy, spd;
      m_hit = 0;
      m_goal = 0;
      if (pause) return;
      if (m_mode == 0) begin
         if (m_cnt == 0) begin
            m_mode = 1; m_vx = m_dir; m_vy = m_tog ? 1 : -1; m_tog = !m_tog;
         end else m_cnt--;
      end else if (m_mode == 1) begin
         nvy = m_vy;
         if (m_by - BS <= YMIN && m_vy < 0) nvy = -m_vy;
         if (m_by + BS >= YMAX && m_vy > 0) nvy = -m_vy;
         spd = (iabs(m_vx) + 1 > MAXS) ? MAXS : iabs(m_vx) + 1;
         nvx = m_vx;
         if (iabs(m_bx - lx) <= HW + BS && iabs(m_by - ly) <= ls + BS && m_vx < 0) begin
            nvx = spd; m_hit = 1;
         end
         if (iabs(m_bx - rx) <= HW + BS && iabs(m_by - ry) <= rs + BS && m_vx > 0) begin
            nvx = -spd; m_hit = 1;
         end
         if (m_hit) n_hits++;
         m_vx = nvx;
         m_vy = nvy;
         if (!m_hit && m_bx - BS <= XMIN)      score_goal(1);
         else if (!m_hit && m_bx + BS >= XMAX) score_goal(0);
         else begin
            m_bx = clampi(m_bx + m_vx, XMIN + BS, XMAX - BS);
            m_by = clampi(m_by + m_vy, YMIN + BS, YMAX - BS);
         end
      end else begin
         if (start) begin m_s1 = 0; m_s2 = 0; m_cnt = SD; m_mode = 0; end
      end
   endtask

   function automatic exp_t snap();
      exp_t e;
      e.bx = m_bx; e.by = m_by; e.s1 = m_s1; e.s2 = m_s2;
      e.hit = m_hit; e.goal = m_goal;
      e.srv = (m_mode == 0); e.over = (m_mode == 2);
      return e;
   endfunction

   // Monitor: one expected frame per clock edge, compared just after the edge
   initial begin
      exp_t e;
      forever begin
         @(posedge frame_clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("BallX", int'(BallX), e.bx);
            chk("BallY", int'(BallY), e.by);
            chk("BallS", int'(BallS), BS);
            chk("Score1", int'(Score1), e.s1);
            chk("Score2", int'(Score2), e.s2);
            chk("Hit", int'(Hit), e.hit);
            chk("Goal", int'(Goal), e.goal);
            chk("Serving", int'(Serving), e.srv);
            chk("GameOver", int'(GameOver), e.over);
         end
      end
   end

   // Stimulus: random paddles, pause bursts, restarts and occasional mid-frame resets
   initial begin
      int pause_left;
      int rst;
      pause_left = 0;
      model_reset();
      last = snap();
      for (int f = 0; f < N_FRAMES; f++) begin
         @(negedge frame_clk);
         rst = (f < 2) || (f == 1500) || ($urandom_range(0, 299) == 0);
         if (f == 700) pause_left = 10;
         else if (pause_left == 0 && $urandom_range(0, 39) == 0) pause_left = $urandom_range(1, 10);
         Pause    = (pause_left > 0);
         if (pause_left > 0) pause_left--;
         Start    = ($urandom_range(0, 7) == 0);
         PaddleX  = 10'($urandom_range(0, 20));
         PaddleY  = 10'($urandom_range(0, 59));
         PaddleS  = 10'($urandom_range(0, 20));
         Paddle2X = 10'($urandom_range(79, 99));
         Paddle2Y = 10'($urandom_range(0, 59));
         Paddle2S = 10'($urandom_range(0, 20));
         Reset    = rst[0];
         if (rst != 0 && f >= 2) begin
            #1;
            chk("hold_before_reset_edge_BallX", int'(BallX), last.bx);
            chk("hold_before_reset_edge_Serving", int'(Serving), last.srv);
            chk("hold_before_reset_edge_Score2", int'(Score2), last.s2);
         end
         if (rst != 0) model_reset();
         else model_step(Pause, Start, PaddleX, PaddleY, PaddleS, Paddle2X, Paddle2Y, Paddle2S);
         last = snap();
         exp_q.push_back(last);
      end
      for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge frame_clk);
      #3;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected frames never compared, required 0", exp_q.size());
      end
      n_checks++;
      if (n_hits == 0 || n_goals == 0 || n_overs == 0) begin
         n_fail++;
         $display("FAIL coverage: hits=%0d goals=%0d game_overs=%0d, required all nonzero", n_hits, n_goals, n_overs);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
